// File: rtl/avalon_master.sv
// Host-side initiator for the 2-bit-address register bus: buffers valid/ready
// commands in a small FIFO, issues them one at a time and returns read responses.
module avalon_master #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_read_valid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_irq,
    output logic              irq_rise,
    output logic              busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD, RESP} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    cmd_t             head;
    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             irq_prev;

    // The extra pointer bit tells a full FIFO from an empty one.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign cnt_done  = (cnt == CNT_W'(TIMEOUT - 1));
    assign busy      = !empty || (state != IDLE);

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{write: cmd_write, address: cmd_address, data: cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            state <= state_d;
        end
    end

    // NOTE: state_d gets its default first so no path through the case infers a latch.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     if (!empty) state_d = head.write ? ISSUE_WR : ISSUE_RD;
            ISSUE_WR: state_d = IDLE;
            ISSUE_RD: state_d = WAIT_RD;
            WAIT_RD:  if (bus_read_valid || cnt_done) state_d = RESP;
            RESP:     if (rsp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Strobes and rsp_valid are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            bus_address <= '0;
            bus_wdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            cnt         <= '0;
            irq_prev    <= 1'b0;
            irq_rise    <= 1'b0;
        end else begin
            bus_write <= (state_d == ISSUE_WR);
            bus_read  <= (state_d == ISSUE_RD);
            rsp_valid <= (state_d == RESP);
            irq_prev  <= bus_irq;
            irq_rise  <= bus_irq && !irq_prev;
            if (pop) begin
                bus_address <= head.address;
                if (head.write) bus_wdata <= head.data;
            end
            if (state == ISSUE_RD) begin
                cnt <= '0;
            end else if (state == WAIT_RD) begin
                if (bus_read_valid) begin
                    rsp_data  <= bus_rdata;
                    rsp_error <= 1'b0;
                end else if (cnt_done) begin
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/avalon_master.md
Name: avalon_master

Overview:
- Bus initiator for the peripheral register interface: the host-side end of the 2-bit-address, 32-bit-data read/write bus that peripheral cores respond on.
- Accepts register commands from an upstream client through a valid/ready port and buffers them in a small command FIFO.
- Issues each command on the bus, one at a time, and returns read data (or a timeout error) through a held response port.
- Sits between a test sequencer or CPU-side logic and one peripheral core's bus.

Parameters:
- DATA_W, 32, width of bus and command data
- ADDR_W, 2, width of register address
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >= 2)
- TIMEOUT, 15, cycles waited for read_valid before flagging an error (>= 1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  target register
- cmd_data  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read response held
- rsp_ready  in  1  client consumes response
- rsp_data  out  DATA_W  captured read data
- rsp_error  out  1  read timed out
- bus_read  out  1  read strobe
- bus_write  out  1  write strobe
- bus_address  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_read_valid  in  1  responder read data valid
- bus_rdata  in  DATA_W  responder read data
- bus_irq  in  1  responder interrupt level
- irq_rise  out  1  one-cycle pulse on a 0->1 edge of bus_irq
- busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: cmd_ready=0 during reset and 1 the cycle after; rsp_valid=0, rsp_data=0, rsp_error=0, bus_read=0, bus_write=0, bus_address=0, bus_wdata=0, irq_rise=0, busy=0.
- Reset also empties the FIFO, sets state to IDLE, clears the timeout counter and clears the previous-irq register.
- Reset mid-operation discards any in-flight command or response. No bus strobe is asserted in the cycle after reset.

Command FIFO:
- Push when cmd_valid && cmd_ready.
- cmd_ready = !full.
- A pushed entry is poppable from the next cycle, so there is no same-cycle bypass.
- Simultaneous push and pop is allowed when not full.
- Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit.

FSM states: IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD, RESP.
- IDLE: if FIFO non-empty, pop the head into the command register at cycle N. Next state is ISSUE_WR or ISSUE_RD.
- ISSUE_WR (cycle N+1): bus_write=1, bus_address and bus_wdata from the command register. Next state IDLE. Back-to-back writes therefore issue every 2 cycles.
- ISSUE_RD (cycle N+1): bus_read=1, bus_address driven. Next state WAIT_RD; counter=0.
- WAIT_RD:
  - If bus_read_valid: rsp_data<=bus_rdata, rsp_error<=0, next state RESP. With a zero-wait responder, read_valid arrives at N+2 and rsp_valid rises at N+3.
  - Otherwise counter++. When counter reaches TIMEOUT-1 without read_valid: rsp_data<=0, rsp_error<=1, next state RESP. The error response is visible TIMEOUT cycles after entering WAIT_RD.
- RESP: rsp_valid=1. rsp_data and rsp_error hold stable until rsp_ready. On rsp_ready, rsp_valid drops the next cycle and the state returns to IDLE. The FIFO is not popped while in RESP, so reads are strictly ordered.

Bus outputs:
- Strobes are registered and high for exactly one cycle per command. bus_read and bus_write are never high together.
- bus_address and bus_wdata hold their last driven value when idle.
- bus_read_valid in any state other than WAIT_RD is ignored.

Interrupt and status:
- irq_rise = bus_irq && !irq_prev, registered, one cycle. It is independent of the FSM.
- busy is combinational from the FIFO and state.

Test Plan:
- Reset, then push write(addr 1, 0x0000_0007) -> bus_write high exactly 1 cycle with bus_address=1 and bus_wdata=7; no bus_read; busy returns to 0.
- Push read(addr 0); responder returns read_valid 1 cycle after bus_read with rdata=0x0000_03E8; rsp_ready held 1 -> rsp_valid at pop+3 with rsp_data=0x3E8 and rsp_error=0.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and the bus stalled by a pending read with rsp_ready=0 -> cmd_ready drops after the 4th accepted entry; with rsp_ready=0, rsp_valid and rsp_data stay stable for 10 cycles; after release, all commands issue in order with no loss or duplication.
- Read to a responder that never asserts read_valid (TIMEOUT=15) -> rsp_valid with rsp_error=1 and rsp_data=0, 15 cycles after WAIT_RD entry; the next queued write issues afterwards.
- Stray bus_read_valid in IDLE and during ISSUE_WR -> no response generated; bus_irq 0->1->1->0->1 -> irq_rise pulses exactly twice.
- Assert reset during WAIT_RD with 2 entries queued -> next cycle all outputs are at reset values and the FIFO is empty; no strobes after reset deasserts until a new push.
